// File: rtl/ifetch_unit.sv
// Instruction-fetch initiator: drives a synchronous-read instruction memory,
// buffers returned {pc, instr} pairs in a small FIFO and presents the head to
// decode with stall flow control and branch redirect.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'd0,
  parameter logic [31:0] PC_STEP    = 32'd1,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  localparam int              PTR_W    = $clog2(FIFO_DEPTH);
  localparam int              CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(FIFO_DEPTH);

  // Circular pointer advance; depth need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Control state
  logic [31:0]      r_req_pc;
  logic             r_inflight;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  // Data state (no reset needed; qualified by control)
  logic [31:0]      r_inflight_pc;
  logic [31:0]      r_pc_mem    [FIFO_DEPTH];
  logic [31:0]      r_instr_mem [FIFO_DEPTH];

  logic             w_pop;
  logic             w_push;
  logic             w_issue;
  logic [CNT_W:0]   w_occ;

  assign if_valid  = (r_count != '0);
  assign if_pc     = if_valid ? r_pc_mem[r_rd_ptr]    : 32'd0;
  assign if_instr  = if_valid ? r_instr_mem[r_rd_ptr] : 32'd0;
  assign imem_addr = r_req_pc;

  // Occupancy seen by the issue decision counts the in-flight read and
  // credits the slot freed by this cycle's pop, so a full-rate stream never
  // bubbles while a stalled stream never overfills.
  assign w_pop   = if_valid & ~stall;
  assign w_occ   = {1'b0, r_count}
                 + {{CNT_W{1'b0}}, r_inflight}
                 - {{CNT_W{1'b0}}, w_pop};
  assign w_issue = ~redirect_valid & (w_occ < DEPTH_C);
  // A redirect drops the response still on the bus; clearing the in-flight
  // flag on the same edge means no later response can belong to the old path.
  assign w_push  = r_inflight & ~redirect_valid;

  // Control: fetch pointer, in-flight flag and FIFO bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_pc   <= RESET_PC;
      r_inflight <= 1'b0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else if (redirect_valid) begin
      r_req_pc   <= redirect_pc;
      r_inflight <= 1'b0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_issue) begin
        r_inflight <= 1'b1;
        r_req_pc   <= r_req_pc + PC_STEP;
      end else begin
        r_inflight <= 1'b0;
      end
      if (w_push) r_wr_ptr <= ptr_next(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Data: remember the issued pc and write returned pairs into the buffer.
  always_ff @(posedge clk) begin
    if (w_issue) r_inflight_pc <= r_req_pc;
    if (w_push) begin
      r_pc_mem[r_wr_ptr]    <= r_inflight_pc;
      r_instr_mem[r_wr_ptr] <= imem_rdata;
    end
  end

  // Buffered plus outstanding entries never exceed the buffer size.
  always_ff @(posedge clk) begin
    if (!rst) assert (int'(r_count) + int'(r_inflight) <= FIFO_DEPTH);
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: a default-reset instance carries the main stream
// tests, a second instance starting near the top of the address space checks
// pc wrap-around.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic [31:0] imem_addr_a, imem_rdata_a, if_pc_a, if_instr_a;
  logic        if_valid_a;
  logic [31:0] imem_addr_b, imem_rdata_b, if_pc_b, if_instr_b;
  logic        if_valid_b;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  bit sb_on = 1'b0;

  always #5 clk = ~clk;

  ifetch_unit dut_a (
    .clk(clk), .rst(rst), .imem_addr(imem_addr_a), .imem_rdata(imem_rdata_a),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid_a), .if_pc(if_pc_a), .if_instr(if_instr_a)
  );

  ifetch_unit #(.RESET_PC(32'hFFFF_FFFE)) dut_b (
    .clk(clk), .rst(rst), .imem_addr(imem_addr_b), .imem_rdata(imem_rdata_b),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid_b), .if_pc(if_pc_b), .if_instr(if_instr_b)
  );

  // Memory contents: mem[i] = 100 + i, 32 words, address taken mod 32.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'd100 + {27'd0, a[4:0]};
  endfunction

  // Registered-read instruction memories.
  always @(posedge clk) begin
    imem_rdata_a <= mem_word(imem_addr_a);
    imem_rdata_b <= mem_word(imem_addr_b);
  end

  // Scoreboard: every head consumed by decode must be the next expected pc.
  always @(negedge clk) begin : sb_mon
    logic [31:0] e;
    if (sb_on && !rst && if_valid_a && !stall) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_stream: consumed pc=%h instr=%0d, required no output", if_pc_a, if_instr_a);
      end else begin
        e = exp_q.pop_front();
        if (if_pc_a !== e || if_instr_a !== mem_word(e)) begin
          errors++;
          $display("FAIL sb_stream: consumed pc=%h instr=%0d, required pc=%h instr=%0d",
                   if_pc_a, if_instr_a, e, mem_word(e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic push_range(input logic [31:0] start, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(i));
  endtask

  // Advance to the first cycle presenting pc as head (stimulus point).
  task automatic wait_head(input logic [31:0] pc);
    int n = 0;
    forever begin
      @(posedge clk); #1;
      if (if_valid_a && if_pc_a == pc) break;
      n++;
      if (n > 60) begin
        checks++; errors++;
        $display("FAIL wait_head: pc %h never presented, required within 60 cycles", pc);
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (imem_addr_a !== 32'd0) begin errors++; $display("FAIL rst_addr: got %h, required %h", imem_addr_a, 32'd0); end
    checks++; if (if_valid_a !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, required 0", if_valid_a); end
    checks++; if (if_pc_a !== 32'd0) begin errors++; $display("FAIL rst_pc: got %h, required 0", if_pc_a); end
    checks++; if (if_instr_a !== 32'd0) begin errors++; $display("FAIL rst_instr: got %h, required 0", if_instr_a); end
    checks++; if (imem_addr_b !== 32'hFFFF_FFFE) begin errors++; $display("FAIL rst_addr_b: got %h, required fffffffe", imem_addr_b); end
    @(posedge clk); #1;
    rst = 1'b0;
    push_range(32'd0, 32);
    sb_on = 1'b1;
  endtask

  // T1: first valid two cycles after reset release, then one pc per cycle.
  task automatic test_stream();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (if_valid_a !== (k >= 2)) begin
        errors++; $display("FAIL stream_valid[%0d]: got %b, required %b", k, if_valid_a, (k >= 2));
      end
      if (k >= 2) begin
        checks++;
        if (if_pc_a !== 32'(k - 2) || if_instr_a !== 32'(98 + k)) begin
          errors++; $display("FAIL stream_pc[%0d]: got pc=%h instr=%0d, required pc=%h instr=%0d",
                             k, if_pc_a, if_instr_a, 32'(k - 2), 98 + k);
        end
      end
    end
  endtask

  // T2: stall holds head 3 while the FIFO fills and fetch stops at pc 5.
  task automatic test_stall();
    wait_head(32'd3);
    stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (if_valid_a !== 1'b1 || if_pc_a !== 32'd3 || if_instr_a !== 32'd103) begin
        errors++; $display("FAIL stall_hold[%0d]: got v=%b pc=%h instr=%0d, required v=1 pc=3 instr=103",
                           k, if_valid_a, if_pc_a, if_instr_a);
      end
      checks++;
      if (imem_addr_a !== 32'd5) begin
        errors++; $display("FAIL stall_addr[%0d]: got %h, required 5", k, imem_addr_a);
      end
    end
    @(posedge clk); #1;
    stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (if_valid_a !== 1'b1 || if_pc_a !== 32'(3 + k)) begin
        errors++; $display("FAIL stall_release[%0d]: got v=%b pc=%h, required v=1 pc=%h",
                           k, if_valid_a, if_pc_a, 32'(3 + k));
      end
    end
  endtask

  // T3/T4: redirect to pc 20, optionally together with stall.
  task automatic test_redirect(input logic [31:0] at_pc, input logic with_stall);
    wait_head(at_pc);
    redirect_valid = 1'b1;
    redirect_pc    = 32'd20;
    stall          = with_stall;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    stall          = 1'b0;
    push_range(32'd20, 12);
    @(negedge clk);
    checks++;
    if (if_valid_a !== 1'b0 || imem_addr_a !== 32'd20) begin
      errors++; $display("FAIL redir_flush(stall=%b): got v=%b addr=%h, required v=0 addr=00000014",
                         with_stall, if_valid_a, imem_addr_a);
    end
    @(negedge clk);
    checks++;
    if (if_valid_a !== 1'b0) begin
      errors++; $display("FAIL redir_gap(stall=%b): got v=%b pc=%h, required v=0", with_stall, if_valid_a, if_pc_a);
    end
    @(negedge clk);
    checks++;
    if (if_valid_a !== 1'b1 || if_pc_a !== 32'd20 || if_instr_a !== 32'd120) begin
      errors++; $display("FAIL redir_target(stall=%b): got v=%b pc=%h instr=%0d, required v=1 pc=14 instr=120",
                         with_stall, if_valid_a, if_pc_a, if_instr_a);
    end
  endtask

  // T5: one-cycle reset mid-stream restarts fetch at pc 0.
  task automatic test_midstream_reset();
    wait_head(32'd25);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    push_range(32'd0, 32);
    @(negedge clk);
    checks++;
    if (if_valid_a !== 1'b0 || imem_addr_a !== 32'd0) begin
      errors++; $display("FAIL mid_rst: got v=%b addr=%h, required v=0 addr=0", if_valid_a, imem_addr_a);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (if_valid_a !== 1'b1 || if_pc_a !== 32'd0 || if_instr_a !== 32'd100) begin
      errors++; $display("FAIL mid_rst_restart: got v=%b pc=%h instr=%0d, required v=1 pc=0 instr=100",
                         if_valid_a, if_pc_a, if_instr_a);
    end
  endtask

  // T6: pc wraps from FFFFFFFF to 0 without a bubble.
  task automatic test_wrap();
    logic [31:0] ep;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    push_range(32'd0, 32);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      ep = 32'hFFFF_FFFE + 32'(k - 2);
      checks++;
      if (if_valid_b !== (k >= 2)) begin
        errors++; $display("FAIL wrap_valid[%0d]: got %b, required %b", k, if_valid_b, (k >= 2));
      end
      if (k >= 2) begin
        checks++;
        if (if_pc_b !== ep || if_instr_b !== mem_word(ep)) begin
          errors++; $display("FAIL wrap_pc[%0d]: got pc=%h instr=%0d, required pc=%h instr=%0d",
                             k, if_pc_b, if_instr_b, ep, mem_word(ep));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect(32'd8, 1'b0);
    test_redirect(32'd23, 1'b1);
    test_midstream_reset();
    test_wrap();
    repeat (4) @(negedge clk);
    sb_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
